// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_F = 2'd2
  } arb_state_e;

  localparam logic OWNER_DATA  = 1'b1;
  localparam logic OWNER_FETCH = 1'b0;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; hit_o is high while the count sits at LIMIT.
module arb_sat_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between fetch and data ports: data priority,
// bounded fetch starvation, registered outputs, timeout abort of hung accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o,
  output logic              owner_o
);

  // Expiry is detected in the last allowed mem_req cycle, so the counter stops one short.
  localparam int unsigned TMO_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  arb_state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              owner_q, owner_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic in_gnt, ack_busy, d_win, grant_d, grant_f, done, expire;
  logic starve_hit, tmo_hit;

  // The completion cycle is a turnaround: both requesters re-arbitrate together next cycle.
  assign in_gnt   = (state_q != IDLE);
  assign ack_busy = if_ack_q | d_ack_q;
  assign d_win    = d_req_i && (!if_req_i || !starve_hit || (STARVE_LIMIT == 0));
  assign grant_d  = (state_q == IDLE) && !ack_busy && d_win;
  assign grant_f  = (state_q == IDLE) && !ack_busy && !d_win && if_req_i;
  assign done     = in_gnt && mem_ack_i;
  assign expire   = in_gnt && !mem_ack_i && tmo_hit && (TIMEOUT_CYCLES != 0);

  arb_sat_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr_i (grant_f || (grant_d && !if_req_i)),
    .inc_i (grant_d && if_req_i),
    .hit_o (starve_hit)
  );

  arb_sat_counter #(.LIMIT(TMO_LIMIT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (grant_d || grant_f),
    .inc_i (in_gnt && !mem_ack_i),
    .hit_o (tmo_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = GNT_D;
        end else if (grant_f) begin
          state_d = GNT_F;
        end
      end
      GNT_D, GNT_F: begin
        if (done || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = (state_d != IDLE);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = '0;
    d_rdata_d   = '0;
    err_d       = 1'b0;
    if (grant_d) begin
      mem_we_d    = d_we_i;
      mem_addr_d  = d_addr_i;
      mem_wdata_d = d_wdata_i;
      owner_d     = OWNER_DATA;
    end else if (grant_f) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr_i;
      mem_wdata_d = '0;
      owner_d     = OWNER_FETCH;
    end
    if (done || expire) begin
      err_d = expire;
      if (state_q == GNT_D) begin
        d_ack_d   = 1'b1;
        d_rdata_d = (done && !mem_we_q) ? mem_rdata_i : '0;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = done ? mem_rdata_i : '0;
      end
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign owner_o     = owner_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign err_o       = err_q;

endmodule
